// File: rtl/barrel_rotator_pkg.sv
// rtl/barrel_rotator_pkg.sv - shared types and constants for the pipelined barrel rotator
package barrel_rotator_pkg;

  typedef enum logic [1:0] {
    OP_ROT = 2'd0,
    OP_LSH = 2'd1,
    OP_ASH = 2'd2,
    OP_RSV = 2'd3
  } op_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_rotator_stage.sv
// rtl/barrel_rotator_stage.sv - combinational move by 2^K positions for one barrel level
module barrel_rotator_stage
  import barrel_rotator_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 0
) (
  input  logic [N-1:0] data_i,
  input  logic         dir_i,
  input  op_t          op_i,
  input  logic         fill_i,
  input  logic         en_i,
  output logic [N-1:0] data_o
);

  localparam int S = 1 << K;
  // Upper S bits set: the positions vacated by a right move, filled with the sign bit
  localparam logic [N-1:0] HI_MASK = ~({N{1'b1}} >> S);

  // Select the moved word for the requested op/direction; pass through when this amt bit is clear
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_LSH: begin
          data_o = (dir_i == DIR_RIGHT) ? (data_i >> S) : (data_i << S);
        end
        OP_ASH: begin
          data_o = (dir_i == DIR_RIGHT) ? ((data_i >> S) | (fill_i ? HI_MASK : '0))
                                        : (data_i << S);
        end
        default: begin
          // OP_ROT and reserved OP_RSV both rotate
          data_o = (dir_i == DIR_RIGHT) ? ((data_i >> S) | (data_i << (N - S)))
                                        : ((data_i << S) | (data_i >> (N - S)));
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// rtl/pipelined_barrel_rotator.sv - log2(N)-stage registered barrel rotate/shift with global stall
module pipelined_barrel_rotator
  import barrel_rotator_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic          up_dir,
  input  logic [1:0]    up_op,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("pipelined_barrel_rotator: N must be a power of two >= 2");
  end

  // Per-stage pipeline registers; stage SW-1 drives the downstream port
  logic [SW-1:0] valid_q;
  logic [N-1:0]  data_q [SW];
  logic [SW-1:0] amt_q  [SW];
  logic          dir_q  [SW];
  op_t           op_q   [SW];
  logic          fill_q [SW];

  // Inputs seen by each stage: the upstream port for stage 0, the previous register otherwise
  logic [SW-1:0] src_valid;
  logic [N-1:0]  src_data [SW];
  logic [SW-1:0] src_amt  [SW];
  logic          src_dir  [SW];
  op_t           src_op   [SW];
  logic          src_fill [SW];

  logic [N-1:0]  data_d [SW];
  logic          enable;

  assign down_valid = valid_q[SW-1];
  assign down_data  = data_q[SW-1];
  assign enable     = down_ready | ~down_valid;
  assign up_ready   = enable;

  // Route the upstream operand into stage 0 and chain each later stage to its predecessor
  always_comb begin
    src_valid[0] = up_valid & up_ready;
    src_data[0]  = up_data;
    src_amt[0]   = up_amt;
    src_dir[0]   = up_dir;
    src_op[0]    = op_t'(up_op);
    src_fill[0]  = up_data[N-1];
    for (int k = 1; k < SW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_dir[k]   = dir_q[k-1];
      src_op[k]    = op_q[k-1];
      src_fill[k]  = fill_q[k-1];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    barrel_rotator_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .data_i (src_data[k]),
      .dir_i  (src_dir[k]),
      .op_i   (src_op[k]),
      .fill_i (src_fill[k]),
      .en_i   (src_amt[k][k]),
      .data_o (data_d[k])
    );
  end

  // Advance every stage together when enabled; hold everything on a stall; reset clears the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        dir_q[k]  <= DIR_LEFT;
        op_q[k]   <= OP_ROT;
        fill_q[k] <= 1'b0;
      end
    end else if (enable) begin
      valid_q <= src_valid;
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= src_amt[k];
        dir_q[k]  <= src_dir[k];
        op_q[k]   <= src_op[k];
        fill_q[k] <= src_fill[k];
      end
    end
  end

endmodule
